// File: rtl/regfile_wb_pkg.sv
// Shared constants for the write-back register file and retire counter.
// The register-address width is fixed at 5 bits, matching a RISC-V style encoding.
package regfile_wb_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // A write commits only when enabled and aimed at a register other than x0.
    function automatic logic is_write(input logic we, input logic [REG_ADDR_W-1:0] rd);
        return we && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// Write-back beat and decode-stage read ports of the register file.
// The master is the pipeline; the slave is the register file.
interface regfile_wb_if
    import regfile_wb_pkg::*;
#(
    parameter int XLEN = regfile_wb_pkg::XLEN
);
    logic                  hazard_stall;
    logic                  wb_valid;
    logic                  WB_RegWrite;
    logic [REG_ADDR_W-1:0] WB_Rd;
    logic [XLEN-1:0]       WB_WriteData;
    logic [XLEN-1:0]       WB_PC;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;

    modport master (
        output hazard_stall, wb_valid, WB_RegWrite, WB_Rd, WB_WriteData, WB_PC,
        output rs1_addr, rs2_addr,
        input  rs1_data, rs2_data
    );

    modport slave (
        input  hazard_stall, wb_valid, WB_RegWrite, WB_Rd, WB_WriteData, WB_PC,
        input  rs1_addr, rs2_addr,
        output rs1_data, rs2_data
    );

endinterface

// File: rtl/regfile_wb_retire_counter.sv
// Retired-instruction counter and last-retired PC capture.
// The 64-bit count wraps silently; a stalled beat never retires.
module retire_counter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            retire,
    input  logic [XLEN-1:0] pc,
    output logic [63:0]     instret,
    output logic [XLEN-1:0] last_retired_pc
);

    logic [63:0]     instret_reg;
    logic [XLEN-1:0] last_pc_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret_reg <= '0;
            last_pc_reg <= '0;
        end else if (retire) begin
            instret_reg <= instret_reg + 64'd1;
            last_pc_reg <= pc;
        end
    end

    assign instret         = instret_reg;
    assign last_retired_pc = last_pc_reg;

endmodule

// File: rtl/regfile_wb.sv
// Architectural register file with write-to-read bypass and retire tracking.
// x0 is hardwired to zero; reads are combinational and forced to zero in reset.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int XLEN  = regfile_wb_pkg::XLEN,
    parameter int NREGS = regfile_wb_pkg::NREGS
) (
    input  logic            clk,
    input  logic            reset_n,
    regfile_wb_if.slave     bus,
    output logic [63:0]     instret,
    output logic [XLEN-1:0] last_retired_pc
);

    logic [XLEN-1:0]       regs [NREGS];
    logic                  wr_en;
    logic                  retire;
    logic [REG_ADDR_W-1:0] rd_addr [2];
    logic [XLEN-1:0]       rd_data [2];

    assign wr_en  = is_write(bus.WB_RegWrite, bus.WB_Rd);
    assign retire = bus.wb_valid && !bus.hazard_stall;

    // Writes proceed during a stall: the repeated beat rewrites the same value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 1; i < NREGS; i++) begin
                if (bus.WB_Rd == REG_ADDR_W'(i)) begin
                    regs[i] <= bus.WB_WriteData;
                end
            end
        end
    end

    assign rd_addr[0] = bus.rs1_addr;
    assign rd_addr[1] = bus.rs2_addr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            assign rd_data[gi] =
                (!reset_n || rd_addr[gi] == REG_ZERO
                          || int'(rd_addr[gi]) >= NREGS) ? '0 :
                (wr_en && bus.WB_Rd == rd_addr[gi])   ? bus.WB_WriteData :
                                                        regs[rd_addr[gi]];
        end
    endgenerate

    assign bus.rs1_data = rd_data[0];
    assign bus.rs2_data = rd_data[1];

    retire_counter #(
        .XLEN (XLEN)
    ) u_retire (
        .clk             (clk),
        .reset_n         (reset_n),
        .retire          (retire),
        .pc              (bus.WB_PC),
        .instret         (instret),
        .last_retired_pc (last_retired_pc)
    );

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 Parameter XLEN, default 32, data width of registers, write-back data and PC.
REQ-002 Parameter NREGS, default 32, number of architectural registers; the register address width is 5.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 hazard_stall  input  1  global pipeline stall; while high, the write-back beat is a repeat of the previous one.
REQ-006 wb_valid  input  1  write-back beat carries a retiring instruction (not a bubble).
REQ-007 WB_RegWrite  input  1  register write enable from write-back.
REQ-008 WB_Rd  input  5  destination register index.
REQ-009 WB_WriteData  input  XLEN  value to write.
REQ-010 WB_PC  input  XLEN  PC of the retiring instruction.
REQ-011 rs1_addr, rs2_addr  input  5 each  decode-stage read addresses.
REQ-012 rs1_data, rs2_data  output  XLEN each  read data (combinational).
REQ-013 instret  output  64  count of retired instructions.
REQ-014 last_retired_pc  output  XLEN  PC of the most recently retired instruction.

Function
REQ-015 Register x0 SHALL read as 0 at all times, and writes to index 0 SHALL be discarded.
REQ-016 On a rising clk edge with WB_RegWrite=1 and WB_Rd!=0, regs[WB_Rd] SHALL take WB_WriteData; this write occurs whether or not hazard_stall is high, because a repeated write of the same value is idempotent.
REQ-017 Each read port SHALL return regs[addr] combinationally (zero-cycle latency).
REQ-018 Write-to-read bypass: if WB_RegWrite=1, WB_Rd!=0 and WB_Rd==rsN_addr, then rsN_data SHALL equal WB_WriteData in the same cycle.
REQ-019 Both read ports SHALL bypass independently, and both SHALL bypass when both addresses match WB_Rd.
REQ-020 A retire event SHALL be defined as wb_valid=1 and hazard_stall=0 at a rising edge.
REQ-021 On each retire event, instret SHALL increment by exactly 1 and last_retired_pc SHALL take WB_PC, independent of WB_RegWrite.
REQ-022 While wb_valid=1 and hazard_stall=1, instret and last_retired_pc SHALL hold, so a stalled beat is never double-counted.
REQ-023 instret SHALL wrap from 2^64-1 to 0 without any flag.
REQ-024 wb_valid=0 SHALL leave instret and last_retired_pc unchanged.
REQ-025 The block SHALL contain no other state; the read ports have no handshake and are always valid.

Reset
REQ-026 While reset_n=0, all registers, instret and last_retired_pc SHALL be 0 immediately, without waiting for a clock edge.
REQ-027 Assertion of reset_n in the middle of an operation SHALL discard any in-flight write and any in-flight retire.
REQ-028 During reset, the read ports SHALL return 0 for every address, including when the bypass condition holds on WB inputs.
REQ-029 After reset_n is released, the first rising edge SHALL process the write and retire inputs normally.

Structure
REQ-030 A shared package SHALL hold XLEN, NREGS, REG_ADDR_W=5 and the constant REG_ZERO=5'd0.
REQ-031 The instret and last_retired_pc logic SHALL be one sub-module, retire_counter, with inputs clk, reset_n, retire and pc.
REQ-032 The register array and the bypass multiplexers SHALL stay in regfile_wb.

Verification
REQ-033 Write x5=0xDEADBEEF, then read rs1_addr=5 on the next cycle -> rs1_data=0xDEADBEEF.
REQ-034 Apply WB_RegWrite=1, WB_Rd=7, data 0x12345678 with rs1_addr=rs2_addr=7 in the same cycle -> both ports read 0x12345678 before the edge.
REQ-035 Write x0=0xFFFFFFFF, then read rs2_addr=0 -> 0; the same x0 write with rs2_addr=0 in the same cycle -> 0 (no bypass).
REQ-036 Apply 3 valid beats (PCs 0x100, 0x104, 0x108), with hazard_stall=1 for 2 cycles on the second beat -> instret=3 and last_retired_pc=0x108.
REQ-037 Preload instret to 2^64-1 by force, then one retire -> instret=0.
REQ-038 Assert reset_n=0 mid-cycle after writing x3=0xA5 -> x3, instret and last_retired_pc read 0 at once, and a write pending in that cycle is lost.
